// File: rtl/int_arbiter_if.sv
// int_arbiter_if: signal bundle between the CSR unit, pipeline injector and int_arbiter.
// Signals: raw interrupt lines (i_int_ext/timer/soft), CSR state (i_mip_sw, i_mie,
// i_mideleg, i_status, i_priv), handshake (i_int_ack, i_flush, o_int_req),
// trap info (o_int_cause, o_int_to_s) and synchronised pending bits (o_mip_hw).
// slave = the arbiter, master = the surrounding CSR/pipeline logic.
interface int_arbiter_if;
    logic        i_int_ext;
    logic        i_int_timer;
    logic        i_int_soft;
    logic [31:0] i_mip_sw;
    logic [31:0] i_mie;
    logic [31:0] i_mideleg;
    logic [31:0] i_status;
    logic [1:0]  i_priv;
    logic        i_int_ack;
    logic        i_flush;
    logic [31:0] o_mip_hw;
    logic        o_int_req;
    logic [31:0] o_int_cause;
    logic        o_int_to_s;

    modport slave (
        input  i_int_ext, i_int_timer, i_int_soft, i_mip_sw, i_mie, i_mideleg,
               i_status, i_priv, i_int_ack, i_flush,
        output o_mip_hw, o_int_req, o_int_cause, o_int_to_s
    );

    modport master (
        output i_int_ext, i_int_timer, i_int_soft, i_mip_sw, i_mie, i_mideleg,
               i_status, i_priv, i_int_ack, i_flush,
        input  o_mip_hw, o_int_req, o_int_cause, o_int_to_s
    );
endinterface

// File: rtl/int_arbiter.sv
// int_arbiter: picks the highest-priority takeable interrupt and drives a registered
// request/ack handshake toward the pipeline injector, with a guard window after each ack.
// Ports: i_clk (rising edge), i_rst_n (async assert, active-low),
//        bus (int_arbiter_if.slave): raw lines, CSR state, ack/flush in;
//        o_mip_hw, o_int_req, o_int_cause, o_int_to_s out.
// Build option: INT_SYNC_EN defined -> two-flop synchroniser on each raw line;
//               undefined -> single register stage (sources must be synchronous).
module int_arbiter #(
    parameter int GUARD_CYCLES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    int_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, GUARD = 2'd2} state_t;
    localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);

    logic [2:0] raw_lines, hw_q;
    assign raw_lines = {bus.i_int_ext, bus.i_int_timer, bus.i_int_soft};

`ifdef INT_SYNC_EN
    logic [2:0] sync_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            hw_q   <= '0;
        end else begin
            sync_q <= raw_lines;
            hw_q   <= sync_q;
        end
    end
`else
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) hw_q <= '0;
        else          hw_q <= raw_lines;
    end
`endif

    logic [31:0] mip_hw;
    assign mip_hw = {20'd0, hw_q[2], 3'd0, hw_q[1], 3'd0, hw_q[0], 3'd0};
    assign bus.o_mip_hw = mip_hw;

    logic        m_ok, s_ok;
    logic [31:0] cand, take_m, take_s;
    assign m_ok   = (bus.i_priv != 2'd3) | bus.i_status[3];
    assign s_ok   = (bus.i_priv == 2'd0) | ((bus.i_priv == 2'd1) & bus.i_status[1]);
    assign cand   = (bus.i_mip_sw | mip_hw) & bus.i_mie;
    assign take_m = cand & ~bus.i_mideleg & {32{m_ok}};
    assign take_s = cand &  bus.i_mideleg & {32{s_ok}};

    logic unused_status;
    assign unused_status = ^{bus.i_status[31:4], bus.i_status[2], bus.i_status[0]};

    // Participating bits folded into priority order: [0]=11 [1]=3 [2]=7 [3]=9 [4]=1 [5]=5.
    // The M group wins outright whenever it has any candidate.
    logic [5:0] pri_m, pri_s, pri;
    logic [4:0] code;
    logic       any_m;
    assign pri_m = {take_m[5], take_m[1], take_m[9], take_m[7], take_m[3], take_m[11]};
    assign pri_s = {take_s[5], take_s[1], take_s[9], take_s[7], take_s[3], take_s[11]};
    assign any_m = |pri_m;
    assign pri   = any_m ? pri_m : pri_s;
    assign code  = pri[0] ? 5'd11 : pri[1] ? 5'd3 : pri[2] ? 5'd7 :
                   pri[3] ? 5'd9  : pri[4] ? 5'd1 : pri[5] ? 5'd5 : 5'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] cause_q, cause_d;
    logic        to_s_q, to_s_d, req_q, req_d, still_ok;

    // The held request is re-evaluated against its own target group, so a change of
    // delegation, status or privilege withdraws it just like a cleared enable.
    assign still_ok = to_s_q ? take_s[cause_q[4:0]] : take_m[cause_q[4:0]];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        to_s_d  = to_s_q;
        case (state_q)
            IDLE: if (|pri && !bus.i_flush) begin
                state_d = REQ;
                cause_d = {1'b1, 26'd0, code};
                to_s_d  = ~any_m;
            end
            REQ: if (bus.i_flush) state_d = IDLE;
                 else if (bus.i_int_ack) begin
                     state_d = GUARD;
                     cnt_d   = GUARD_LOAD;
                 end else if (!still_ok) state_d = IDLE;
            GUARD: if (cnt_q == 4'd0) state_d = IDLE;
                   else cnt_d = cnt_q - 4'd1;
            default: state_d = IDLE;
        endcase
        req_d = (state_d == REQ);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cause_q <= '0;
            to_s_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            to_s_q  <= to_s_d;
            req_q   <= req_d;
        end
    end

    assign bus.o_int_req   = req_q;
    assign bus.o_int_cause = cause_q;
    assign bus.o_int_to_s  = to_s_q;
endmodule
